// File: rtl/alu_unit.sv
// Registered integer ALU for the execute stage.
// One-cycle latency, one operation per cycle, flags registered with the result.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SRA  = 4'h8,
    OP_SLTU = 4'h9
  } op_e;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] r;
  logic             ov;
  logic             lt_s;
  logic             lt_u;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    r  = '0;
    ov = 1'b0;
    case (alu_op)
      OP_ADD: begin
        r  = sum;
        ov = (a[WIDTH-1] == b[WIDTH-1]) &&
             (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r  = diff;
        ov = (a[WIDTH-1] != b[WIDTH-1]) &&
             (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      OP_SRA:  r = $unsigned($signed(a) >>> shamt);
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, lt_u};
      default: begin
        r  = '0;
        ov = 1'b0;
      end
    endcase
  end

  // Data and flags hold when idle; only out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= r;
        zero     <= (r == '0);
        negative <= r[WIDTH-1];
        overflow <= ov;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, random ops
// against an arithmetic reference model, hold and async reset.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        out_valid;
  logic [35:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [35:0] RST_VEC = {32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam longint MAXI = 64'sh7FFF_FFFF;
  localparam longint MINI = -64'sh8000_0000;

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .alu_op(alu_op),
    .result(result),
    .zero(zero),
    .negative(negative),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  assign obs = {result, zero, negative, overflow, out_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {result, zero, negative, overflow, out_valid} after a valid op.
  function automatic logic [35:0] model(input logic [3:0] op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    logic        ov;
    longint      s;
    int          sh;
    r  = 32'h0;
    ov = 1'b0;
    sh = int'(y % 32);
    case (op)
      4'h0: begin
        s  = longint'($signed(x)) + longint'($signed(y));
        r  = x + y;
        ov = (s > MAXI) || (s < MINI);
      end
      4'h1: begin
        s  = longint'($signed(x)) - longint'($signed(y));
        r  = x - y;
        ov = (s > MAXI) || (s < MINI);
      end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h6: r = x << sh;
      4'h7: r = x >> sh;
      4'h8: r = $unsigned($signed(x) >>> sh);
      4'h9: r = (x < y) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    return {r, (r == 32'h0), r[31], ov, 1'b1};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    alu_op   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 4'h0;
    a        = 32'd5;
    b        = 32'd6;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, RST_VEC);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0]  d_op [15];
    logic [31:0] d_a  [15];
    logic [31:0] d_b  [15];
    logic [31:0] d_r  [15];
    logic [35:0] e;
    d_op = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
             4'h5, 4'h9, 4'hC, 4'h6, 4'h7, 4'h8, 4'h1};
    d_a  = '{32'd10, 32'h7FFFFFFF, 32'd30, 32'd20, 32'hF0F0F0F0,
             32'hF0F0F0F0, 32'hF0F0F0F0, 32'd10, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'h12345678, 32'd8, 32'd32, 32'h80000000,
             32'h80000000};
    d_b  = '{32'd20, 32'd1, 32'd20, 32'd20, 32'h0F0F0F0F,
             32'h0F0F0F0F, 32'h0F0F0F0F, 32'd20, 32'd1, 32'd1,
             32'h9ABCDEF0, 32'd2, 32'd2, 32'h24, 32'd1};
    d_r  = '{32'd30, 32'h80000000, 32'd10, 32'd0, 32'h0,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0,
             32'd32, 32'd8, 32'hF8000000, 32'h7FFFFFFF};
    for (int i = 0; i < 15; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      e = model(d_op[i], d_a[i], d_b[i]);
      checks++;
      if (result !== d_r[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h",
                 i, result, d_r[i]);
      end
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %h want %h", i, obs, e);
      end
    end
    // Spot checks of the flag rules from the vectors above.
    issue(4'h0, 32'h7FFFFFFF, 32'd1);
    checks++;
    if ({overflow, negative, zero} !== 3'b110) begin
      errors++;
      $display("FAIL add_overflow: got ov=%b n=%b z=%b want 1 1 0",
               overflow, negative, zero);
    end
    issue(4'h1, 32'd20, 32'd20);
    checks++;
    if ({zero, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL sub_zero: got z=%b ov=%b want 1 0", zero, overflow);
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] e;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(0, 9));
      x  = $urandom;
      y  = $urandom;
      issue(op, x, y);
      e = model(op, x, y);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      alu_op   = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {e[35:1], 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs,
                 {e[35:1], 1'b0});
      end
    end
  endtask

  task automatic test_random;
    logic [35:0] e;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        v;
    e = obs;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom);
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = x;
        1: x = 32'h80000000;
        2: y = 32'h7FFFFFFF;
        3: y = 32'($urandom_range(0, 40));
        default: ;
      endcase
      v        = ($urandom_range(0, 3) != 0);
      alu_op   = op;
      a        = x;
      b        = y;
      in_valid = v;
      @(posedge clk);
      #1;
      e = v ? model(op, x, y) : {e[35:1], 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: got %h want %h",
                 i, op, x, y, obs, e);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [35:0] e;
    issue(4'h3, 32'h0000F000, 32'h80000001);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, RST_VEC);
    end
    issue(4'h0, 32'd1, 32'd2);
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL reset_sampled: got %h want %h", obs, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_valid: got %b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    e = model(4'h0, 32'd1, 32'd2);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL first_after_release: got %h want %h", obs, e);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered 32-bit integer ALU for the datapath execute stage. Takes two 32-bit operands and a 4-bit operation code, and produces a 32-bit result plus status flags one clock cycle later. Operation-code encoding matches the control decoder: 0x0–0x7 are the core ops, and 0x8–0x9 extend the set.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is required to be supported.

Ports:
- `clk`  input  1: single system clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `in_valid`  input  1: operands and opcode are valid this cycle.
- `a`  input  32: operand A.
- `b`  input  32: operand B; also supplies the shift amount.
- `alu_op`  input  4: operation select.
- `result`  output  32: registered result.
- `zero`  output  1: registered flag, 1 when `result` == 0.
- `negative`  output  1: registered flag, equal to `result[31]`.
- `overflow`  output  1: registered signed-overflow flag; meaningful for ADD/SUB only, 0 for all other ops.
- `out_valid`  output  1: `result` and flags were updated by the previous cycle's `in_valid`.

## Operation
Opcode map (the combinational value `r` computed from `a`, `b`):
- 0x0 ADD: `r` = a + b, modulo 2^32. `overflow` = (a[31]==b[31]) && (r[31]!=a[31]).
- 0x1 SUB: `r` = a − b, modulo 2^32. `overflow` = (a[31]!=b[31]) && (r[31]!=a[31]).
- 0x2 AND: `r` = a & b.
- 0x3 OR: `r` = a | b.
- 0x4 XOR: `r` = a ^ b.
- 0x5 SLT: `r` = 1 if $signed(a) < $signed(b), else 0 (zero-extended to 32 bits).
- 0x6 SLL: `r` = a << b[4:0]; b[31:5] are ignored.
- 0x7 SRL: `r` = a >> b[4:0], logical (zero fill).
- 0x8 SRA: `r` = a >>> b[4:0], arithmetic (sign fill from a[31]).
- 0x9 SLTU: `r` = 1 if unsigned a < unsigned b, else 0.
- 0xA–0xF: reserved; `r` = 0, `overflow` = 0. No error is signalled.

Flags are computed from `r` in the same cycle and registered together with it:
- `zero` = (r == 0).
- `negative` = r[31].

Update and hold rules:
- `in_valid` = 1 at a rising edge: `result`, `zero`, `negative`, `overflow` load the new values, and `out_valid` is set to 1.
- `in_valid` = 0 at a rising edge: `result` and all three flags hold their previous values, and `out_valid` is set to 0.
- No backpressure: a new operation may be issued every cycle.

## Timing
- Latency is exactly 1 cycle. Operands sampled at edge N appear on the outputs immediately after edge N, with `out_valid` high from edge N to edge N+1.
- Throughput is 1 operation per cycle. Back-to-back valids yield back-to-back results, with `out_valid` held continuously high.
- Reset values while `rst_n` = 0, forced asynchronously and independent of `clk`:
  - `result` = 0
  - `zero` = 1
  - `negative` = 0
  - `overflow` = 0
  - `out_valid` = 0
- Reset mid-operation: any in-flight result is discarded; `out_valid` is never asserted for an operation sampled while `rst_n` = 0.
- First sampling after reset release occurs at the first rising edge with `rst_n` = 1.
- Inputs must be stable around the rising edge. The combinational path `a`/`b` → `r` → register must close within one clock period.

## Test plan
- ADD: a=10, b=20, op=0x0 → next cycle `result`=30, `zero`=0, `overflow`=0, `out_valid`=1. Also a=0x7FFFFFFF, b=1 → `result`=0x80000000, `overflow`=1, `negative`=1.
- SUB and zero flag: a=30, b=20, op=0x1 → `result`=10, `zero`=0. Then a=20, b=20 → `result`=0, `zero`=1.
- Logic ops: a=0xF0F0F0F0, b=0x0F0F0F0F:
  - op 0x2 → `result`=0x00000000, `zero`=1.
  - op 0x3 → `result`=0xFFFFFFFF.
  - op 0x4 → `result`=0xFFFFFFFF.
- Compares: a=10, b=20, op 0x5 → 1.
  - a=0xFFFFFFFF, b=1, op 0x5 → 1.
  - a=0xFFFFFFFF, b=1, op 0x9 → 0.
  - Reserved op 0xC → 0.
- Shifts:
  - a=8, b=2, op 0x6 → 32.
  - a=32, b=2, op 0x7 → 8.
  - a=0x80000000, b=0x24, op 0x8 → 0xF8000000 (shift amount 4 from b[4:0]).
- Control: issue ops back-to-back, then drop `in_valid` → outputs hold and `out_valid`=0. Assert `rst_n`=0 mid-cycle → outputs go to their reset values immediately, without waiting for a clock edge.
